delay_line_tapped: RTL and testbench
====================================

Name: delay_line_tapped

Overview:
Multi-channel, valid-tagged delay line with a run-time selectable tap, stall (enable) and flush. It is the parametrised successor of the fixed-depth delay: the same register-chain role for aligning pixel/control data in the VGA pipeline, plus stall, tap select, primed status and flush. It sits between pipeline stages whose latencies differ or change with mode.

Parameters:
DATA_WIDTH, 8, bits per channel (>=1)
CHANNELS, 1, number of parallel channels sharing one valid/enable (>=1)
MAX_DELAY, 4, number of register stages, i.e. the largest selectable delay (>=1)
TAP_W, $clog2(MAX_DELAY+1), width of the tap select; derived, not overridden

Ports:
clk_i  input  1  clock, all logic on rising edge
arstn_i  input  1  reset, synchronous, active-low
en_i  input  1  advance chain this cycle; 0 = stall (all stages hold)
flush_i  input  1  synchronous clear of valid bits, data and fill count
delay_sel_i  input  TAP_W  selected delay in enabled cycles, 0..MAX_DELAY
valid_i  input  1  data_i qualifier
data_i  input  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
valid_o  output  1  valid of selected tap
data_o  output  CHANNELS*DATA_WIDTH  data of selected tap
primed_o  output  1  at least delay_sel_i enabled shifts since reset/flush

Behaviour:
- Stages: stage[1..MAX_DELAY], each holding {valid, data}. On a clock edge with en_i=1: stage[1]<={valid_i,data_i}, stage[k]<=stage[k-1]. With en_i=0 all stages hold.
- Reset (arstn_i=0 at edge): all stage valid and data bits go to 0; fill_cnt goes to 0. After reset, valid_o=0 and data_o=0 for any delay_sel_i>=1.
- Flush: flush_i=1 at an edge has the same effect as reset and overrides en_i. The input presented that cycle is dropped. Reset has priority over flush.
- Tap select (combinational): sel = min(delay_sel_i, MAX_DELAY).
  - sel=0: valid_o/data_o = valid_i/data_i (zero-latency bypass).
  - sel=k>0: valid_o/data_o = stage[k].
  - Out-of-range values clamp; they are not an error.
- Latency: for sel=k and en_i held at 1, an input accepted at edge n appears on the outputs after edge n+k-1, i.e. exactly k cycles later. A stall stretches this by the number of en_i=0 cycles.
- Changing delay_sel_i mid-stream: the outputs switch tap in the same cycle, with no reorder or duplicate protection. Items may be skipped or repeated. Upstream flushes when correctness matters.
- Fill counter:
  - fill_cnt has width TAP_W. It increments on each enabled non-flush edge and saturates at MAX_DELAY.
  - primed_o = (fill_cnt >= sel), so primed_o=1 whenever sel=0.
  - primed_o is independent of valid_i (it counts shifts, not valid items).
- Channels share valid, enable, flush and tap; there is no per-channel skew.
- No combinational path from en_i or flush_i to the outputs. The only combinational input-to-output paths are from delay_sel_i and from the sel=0 bypass.

Optional Feature:
Macro DELAY_LINE_GATE_DATA_EN.
- Defined: data_o is forced to all-zero whenever valid_o=0, for every tap including bypass.
- Undefined: data_o shows raw stage contents regardless of valid, which saves one AND gate per output bit.

Decomposition:
- Package delay_line_pkg: function tap_w(max_delay) returning $clog2(max_delay+1); typedef stage_ctrl_t {en, flush}.
- One natural sub-module, delay_line_stage: a single {valid, data} register with synchronous active-low reset, enable and flush, instantiated MAX_DELAY times in a generate loop.
- Tap mux and fill counter stay in the top level.

Test Plan:
- Reset then MAX_DELAY=4, sel=3, en=1, drive data 0x11,0x22,0x33 with valid=1 at cycles 0..2 -> valid_o first high after 3rd edge with data_o=0x11, then 0x22, 0x33; primed_o rises at the same edge.
- sel=2, send 0xA5; hold en_i=0 for 3 cycles after the first edge -> 0xA5 appears on data_o 5 cycles after acceptance; outputs frozen during the stall.
- Fill stages with 0x01..0x04, assert flush_i together with en_i=1 and data 0x55 -> next cycle valid_o=0, primed_o=0 (sel=4), 0x55 never emerges.
- sel=0 -> data_o/valid_o track data_i/valid_i in the same cycle; primed_o=1 straight after reset. sel=7 with MAX_DELAY=4 -> behaves exactly as sel=4.
- CHANNELS=3, DATA_WIDTH=8, data_i=0x30_20_10, sel=1 -> data_o=0x302010 one cycle later, channel order preserved.
- With DELAY_LINE_GATE_DATA_EN, send data 0xFF with valid_i=0 -> data_o=0x00 at the tap. Without the macro -> data_o=0xFF with valid_o=0.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the tapped delay line.
// Width helper for the tap select and the per-stage control bundle.
package delay_line_pkg;

  // Bits needed to encode a delay in the range 0..max_delay.
  function automatic int tap_w(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Control shared by every stage of the chain.
  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/delay_line_stage.sv
// One {valid, data} register of the delay chain.
// Synchronous active-low reset, flush clears the stage, enable loads it.
module delay_line_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  stage_ctrl_t      ctrl,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // Reset beats flush, flush beats enable; otherwise the stage holds.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (ctrl.flush) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (ctrl.en) begin
      valid_reg <= valid_d;
      data_reg  <= data_d;
    end
  end

  assign valid_q = valid_reg;
  assign data_q  = data_reg;

endmodule

// File: rtl/delay_line_tapped.sv
// Multi-channel valid-tagged delay line with run-time tap select,
// stall, flush and a primed indicator.
// Optional build macro DELAY_LINE_GATE_DATA_EN: when defined, data_o is
// forced to zero whenever valid_o is low (bypass tap included).
module delay_line_tapped
  import delay_line_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int CHANNELS   = 1,
  parameter  int MAX_DELAY  = 4,
  localparam int TAP_W      = tap_w(MAX_DELAY)
) (
  input  logic                           clk_i,
  input  logic                           arstn_i,
  input  logic                           en_i,
  input  logic                           flush_i,
  input  logic [TAP_W-1:0]               delay_sel_i,
  input  logic                           valid_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  output logic                           valid_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic                           primed_o
);

  localparam int W = CHANNELS * DATA_WIDTH;

  // Index 0 is the live input so the tap mux treats bypass like any stage.
  logic         valid_chain [0:MAX_DELAY];
  logic [W-1:0] data_chain  [0:MAX_DELAY];

  stage_ctrl_t      stage_ctrl;
  logic [TAP_W-1:0] sel_idx;
  logic [TAP_W-1:0] fill_cnt_reg;
  logic             valid_tap;
  logic [W-1:0]     data_tap;

  assign stage_ctrl     = '{en: en_i, flush: flush_i};
  assign valid_chain[0] = valid_i;
  assign data_chain[0]  = data_i;

  generate
    for (genvar gi = 1; gi <= MAX_DELAY; gi++) begin : g_stage
      delay_line_stage #(
        .WIDTH (W)
      ) u_stage (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .ctrl    (stage_ctrl),
        .valid_d (valid_chain[gi-1]),
        .data_d  (data_chain[gi-1]),
        .valid_q (valid_chain[gi]),
        .data_q  (data_chain[gi])
      );
    end
  endgenerate

  // Clamp the requested delay; out-of-range requests pick the last stage.
  always_comb begin
    sel_idx = delay_sel_i;
    if (delay_sel_i > TAP_W'(MAX_DELAY)) begin
      sel_idx = TAP_W'(MAX_DELAY);
    end
  end

  // Count enabled shifts since reset/flush, saturating at the chain depth.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      fill_cnt_reg <= '0;
    end else if (flush_i) begin
      fill_cnt_reg <= '0;
    end else if (en_i && (fill_cnt_reg != TAP_W'(MAX_DELAY))) begin
      fill_cnt_reg <= fill_cnt_reg + TAP_W'(1);
    end
  end

  // Tap mux plus optional zeroing of data on invalid outputs.
  always_comb begin
    valid_tap = valid_chain[sel_idx];
    data_tap  = data_chain[sel_idx];
`ifdef DELAY_LINE_GATE_DATA_EN
    data_o    = valid_tap ? data_tap : '0;
`else
    data_o    = data_tap;
`endif
    valid_o   = valid_tap;
  end

  assign primed_o = (fill_cnt_reg >= sel_idx);

endmodule

// File: tb/tb_delay_line_tapped.sv
// Directed testbench for delay_line_tapped (3 channels x 8 bits, depth 4).
module tb_delay_line_tapped;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int MD = 4;
  localparam int TW = 3;
  localparam int W  = DW * CH;

  logic          clk;
  logic          arstn;
  logic          en;
  logic          flush;
  logic [TW-1:0] sel;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          primed;

  int n_checks = 0;
  int n_fail   = 0;

  delay_line_tapped #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .MAX_DELAY  (MD)
  ) dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .en_i        (en),
    .flush_i     (flush),
    .delay_sel_i (sel),
    .valid_i     (valid_in),
    .data_i      (data_in),
    .valid_o     (valid_out),
    .data_o      (data_out),
    .primed_o    (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    valid_in = v;
    data_in  = d;
  endtask

  task automatic apply_reset();
    arstn = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0);
    tick();
    tick();
    arstn = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    arstn = 1'b0; en = 1'b1; flush = 1'b0; sel = 3'd3;
    drive(1'b1, 24'hABCDEF);
    tick(); tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 000000", data_out); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed: got %b expected 0", primed); end
    arstn = 1'b1;
    sel = 3'd0;
    drive(1'b0, '0);
    #1;
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL reset_primed_sel0: got %b expected 1", primed); end
    $display("test_reset done");
  endtask

  task automatic test_latency();
    logic [W-1:0] exp_d [0:5];
    logic         exp_v [0:5];
    logic         exp_p [0:5];
    logic [W-1:0] in_d  [0:5];
    exp_d = '{24'h0, 24'h0, 24'h11, 24'h22, 24'h33, 24'h0};
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    in_d  = '{24'h11, 24'h22, 24'h33, 24'h0, 24'h0, 24'h0};
    apply_reset();
    sel = 3'd3;
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, in_d[i]);
      tick();
      $display("latency edge %0d: valid_o=%b data_o=%h primed_o=%b", i + 1, valid_out, data_out, primed);
      n_checks++; if (valid_out !== exp_v[i]) begin n_fail++; $display("FAIL latency_valid[%0d]: got %b expected %b", i, valid_out, exp_v[i]); end
      n_checks++; if (data_out !== exp_d[i]) begin n_fail++; $display("FAIL latency_data[%0d]: got %h expected %h", i, data_out, exp_d[i]); end
      n_checks++; if (primed !== exp_p[i]) begin n_fail++; $display("FAIL latency_primed[%0d]: got %b expected %b", i, primed, exp_p[i]); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    sel = 3'd2;
    drive(1'b1, 24'h0000A5);
    tick();
    en = 1'b0;
    drive(1'b1, 24'h000077);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("stall cycle %0d: valid_o=%b data_o=%h primed_o=%b", i, valid_out, data_out, primed);
      n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, valid_out); end
      n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL stall_primed[%0d]: got %b expected 0", i, primed); end
    end
    en = 1'b1;
    tick();
    $display("stall release: valid_o=%b data_o=%h primed_o=%b", valid_out, data_out, primed);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b expected 1", valid_out); end
    n_checks++; if (data_out !== 24'h0000A5) begin n_fail++; $display("FAIL stall_out_data: got %h expected 0000a5", data_out); end
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL stall_out_primed: got %b expected 1", primed); end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (data_out !== 24'h0000A5) begin n_fail++; $display("FAIL stall_hold_data[%0d]: got %h expected 0000a5", i, data_out); end
    end
    en = 1'b1;
  endtask

  task automatic test_flush();
    apply_reset();
    sel = 3'd4;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i));
      tick();
    end
    $display("flush prefill: valid_o=%b data_o=%h primed_o=%b", valid_out, data_out, primed);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b expected 1", valid_out); end
    n_checks++; if (data_out !== 24'h000001) begin n_fail++; $display("FAIL flush_pre_data: got %h expected 000001", data_out); end
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL flush_pre_primed: got %b expected 1", primed); end
    flush = 1'b1;
    drive(1'b1, 24'h000055);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    $display("flush edge: valid_o=%b data_o=%h primed_o=%b", valid_out, data_out, primed);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_out); end
    n_checks++; if (primed !== 1'b0) begin n_fail++; $display("FAIL flush_primed: got %b expected 0", primed); end
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL flush_data: got %h expected 000000", data_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (valid_out !== 1'b0 || data_out !== 24'h0) begin n_fail++; $display("FAIL flush_drain[%0d]: got v=%b d=%h expected v=0 d=000000", i, valid_out, data_out); end
    end
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL flush_reprime: got %b expected 1", primed); end
  endtask

  task automatic test_bypass_clamp();
    apply_reset();
    sel = 3'd0;
    drive(1'b1, 24'h123456);
    #1;
    $display("bypass: valid_o=%b data_o=%h primed_o=%b", valid_out, data_out, primed);
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b expected 1", valid_out); end
    n_checks++; if (data_out !== 24'h123456) begin n_fail++; $display("FAIL bypass_data: got %h expected 123456", data_out); end
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL bypass_primed: got %b expected 1", primed); end
    drive(1'b0, 24'hABCDEF);
    #1;
`ifdef DELAY_LINE_GATE_DATA_EN
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL bypass_invalid_data: got %h expected 000000", data_out); end
`else
    n_checks++; if (data_out !== 24'hABCDEF) begin n_fail++; $display("FAIL bypass_invalid_data: got %h expected abcdef", data_out); end
`endif
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bypass_invalid_valid: got %b expected 0", valid_out); end

    apply_reset();
    sel = 3'd7;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(8'h0A + i));
      tick();
      if (i == 2) begin
        n_checks++; if (valid_out !== 1'b0 || primed !== 1'b0) begin n_fail++; $display("FAIL clamp_early: got v=%b p=%b expected v=0 p=0", valid_out, primed); end
      end
    end
    $display("clamp sel=7: valid_o=%b data_o=%h primed_o=%b", valid_out, data_out, primed);
    n_checks++; if (valid_out !== 1'b1 || data_out !== 24'h00000A) begin n_fail++; $display("FAIL clamp_sel7: got v=%b d=%h expected v=1 d=00000a", valid_out, data_out); end
    n_checks++; if (primed !== 1'b1) begin n_fail++; $display("FAIL clamp_primed: got %b expected 1", primed); end
    sel = 3'd4;
    #1;
    n_checks++; if (data_out !== 24'h00000A) begin n_fail++; $display("FAIL clamp_sel4: got %h expected 00000a", data_out); end
    sel = 3'd1;
    #1;
    n_checks++; if (data_out !== 24'h00000D) begin n_fail++; $display("FAIL tap_switch_sel1: got %h expected 00000d", data_out); end
  endtask

  task automatic test_channels();
    apply_reset();
    sel = 3'd1;
    drive(1'b1, 24'h302010);
    tick();
    drive(1'b0, '0);
    $display("channels: valid_o=%b data_o=%h", valid_out, data_out);
    n_checks++; if (data_out !== 24'h302010) begin n_fail++; $display("FAIL chan_word: got %h expected 302010", data_out); end
    n_checks++; if (data_out[7:0] !== 8'h10) begin n_fail++; $display("FAIL chan0: got %h expected 10", data_out[7:0]); end
    n_checks++; if (data_out[15:8] !== 8'h20) begin n_fail++; $display("FAIL chan1: got %h expected 20", data_out[15:8]); end
    n_checks++; if (data_out[23:16] !== 8'h30) begin n_fail++; $display("FAIL chan2: got %h expected 30", data_out[23:16]); end
  endtask

  task automatic test_gate();
    apply_reset();
    sel = 3'd1;
    drive(1'b0, 24'h0000FF);
    tick();
    $display("gate invalid: valid_o=%b data_o=%h", valid_out, data_out);
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL gate_valid: got %b expected 0", valid_out); end
`ifdef DELAY_LINE_GATE_DATA_EN
    n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL gate_data: got %h expected 000000", data_out); end
`else
    n_checks++; if (data_out !== 24'h0000FF) begin n_fail++; $display("FAIL gate_data: got %h expected 0000ff", data_out); end
`endif
    drive(1'b1, 24'h0000FF);
    tick();
    n_checks++; if (valid_out !== 1'b1 || data_out !== 24'h0000FF) begin n_fail++; $display("FAIL gate_valid_data: got v=%b d=%h expected v=1 d=0000ff", valid_out, data_out); end
  endtask

  initial begin
    arstn = 1'b0; en = 1'b0; flush = 1'b0; sel = '0;
    valid_in = 1'b0; data_in = '0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bypass_clamp();
    test_channels();
    test_gate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
